mem_port_arbiter: RTL and testbench

- Shares the single unified byte-addressed instruction/data memory of the multicycle MIPS core between two requesters: instruction fetch (I, read-only) and load/store (D, read/write).
- Sequences each access through a 3-state FSM.
- Drives the memory's address, writeData, memread and memwrite pins.
- Returns the memory's out32 word to the winning requester with a single-cycle ack.
- Sits between the control unit/datapath and the memory.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/ack and memory-pin bundle for mem_port_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [DATA_W-1:0] mem_out32;
    logic              busy;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_out32,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_address, mem_writeData, mem_memread, mem_memwrite, busy, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_out32,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_address, mem_writeData, mem_memread, mem_memwrite, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/load-store arbiter for the shared multicycle MIPS memory.
// Optional address checking is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int MEM_TOP = 47
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(MEM_TOP);

    logic [1:0]        state;
    logic              last_grant;   // 1 = D was granted last
    logic              win_d;
    logic              is_store;
    logic              bad_q;
    logic              i_ack;
    logic              d_ack;
    logic              busy;
    logic              err;
    logic              mem_memread;
    logic              mem_memwrite;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic [DATA_W-1:0] mem_writeData;
    logic [ADDR_W-1:0] mem_address;

    logic              grant_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_bad;

    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a > TOP_ADDR);
    endfunction

    // On a tie the requester opposite last_grant wins.
    always_comb begin
        grant_d  = bus.d_req & (~bus.i_req | ~last_grant);
        sel_addr = grant_d ? bus.d_addr : bus.i_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        sel_bad  = addr_illegal(sel_addr);
`else
        sel_bad  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            win_d         <= 1'b0;
            is_store      <= 1'b0;
            bad_q         <= 1'b0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            mem_writeData <= '0;
            mem_address   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    if (bus.i_req || bus.d_req) begin
                        last_grant   <= grant_d;
                        win_d        <= grant_d;
                        is_store     <= grant_d & bus.d_we;
                        bad_q        <= sel_bad;
                        mem_address  <= sel_addr;
                        if (grant_d && bus.d_we)
                            mem_writeData <= bus.d_wdata;
                        mem_memwrite <= grant_d & bus.d_we & ~sel_bad;
                        mem_memread  <= ~(grant_d & bus.d_we) & ~sel_bad;
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory read is combinational, so out32 is valid at this edge.
                    if (!bad_q && !is_store) begin
                        if (win_d)
                            d_rdata <= bus.mem_out32;
                        else
                            i_rdata <= bus.mem_out32;
                    end
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    mem_address  <= '0;
                    i_ack        <= ~win_d;
                    d_ack        <= win_d;
                    err          <= bad_q;
                    state        <= DONE;
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack         = i_ack;
    assign bus.d_ack         = d_ack;
    assign bus.i_rdata       = i_rdata;
    assign bus.d_rdata       = d_rdata;
    assign bus.mem_address   = mem_address;
    assign bus.mem_writeData = mem_writeData;
    assign bus.mem_memread   = mem_memread;
    assign bus.mem_memwrite  = mem_memwrite;
    assign bus.busy          = busy;
    assign bus.err           = err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a byte-array memory model.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int MEM_TOP = 47;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TOP(MEM_TOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;
    int          cyc = 0;
    int          wr_cycles = 0;
    int          overlap = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    assign bus.mem_out32 = {mem[bus.mem_address], mem[bus.mem_address + 6'd1],
                            mem[bus.mem_address + 6'd2], mem[bus.mem_address + 6'd3]};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_memread && bus.mem_memwrite)
            overlap <= overlap + 1;
        if (bus.mem_memwrite) begin
            wr_cycles <= wr_cycles + 1;
            mem[bus.mem_address]         <= bus.mem_writeData[31:24];
            mem[bus.mem_address + 6'd1]  <= bus.mem_writeData[23:16];
            mem[bus.mem_address + 6'd2]  <= bus.mem_writeData[15:8];
            mem[bus.mem_address + 6'd3]  <= bus.mem_writeData[7:0];
        end else if (pl_en) begin
            mem[pl_addr]        <= pl_data[31:24];
            mem[pl_addr + 6'd1] <= pl_data[23:16];
            mem[pl_addr + 6'd2] <= pl_data[15:8];
            mem[pl_addr + 6'd3] <= pl_data[7:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic push(input logic is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(output int at);
        exp_t e;
        logic seen;
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (bus.i_ack || bus.d_ack) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("ack_excl", 32'(bus.i_ack & bus.d_ack), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_who", 32'(bus.d_ack), 32'(e.is_d));
                check("rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
                check("err", 32'(bus.err), 32'(e.err));
            end
            if (bus.d_ack) bus.d_req = 1'b0;
            else           bus.i_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, at, prev, w0, ov0;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        preload(6'd0,  32'h00430822);
        preload(6'd4,  32'h0000ABCD);
        preload(6'd8,  32'hCAFEF00D);
        preload(6'd24, 32'h11111111);
        preload(6'd44, 32'h44444444);

        // Reset held with both requests pending.
        bus.i_req = 1'b1; bus.i_addr = 6'd4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd8;
        repeat (3) begin
            tick();
            check("rst_flags", 32'({bus.i_ack, bus.d_ack, bus.busy, bus.err,
                                    bus.mem_memread, bus.mem_memwrite}), 32'd0);
        end
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_wdata", bus.mem_writeData, 32'd0);
        check("rst_irdata", bus.i_rdata, 32'd0);
        check("rst_drdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
        s = cyc;
        push(1'b0, 32'h0000ABCD, 1'b0);
        push(1'b1, 32'hCAFEF00D, 1'b0);
        tick();
        check("first_addr", 32'(bus.mem_address), 32'd4);
        check("first_rd", 32'({bus.mem_memread, bus.mem_memwrite, bus.busy}), 32'b101);
        wait_ack(at);
        check("first_lat", 32'(at - s), 32'd2);
        prev = at;
        wait_ack(at);
        check("second_space", 32'(at - prev), 32'd3);
        tick();

        // Single fetch from word 0.
        s = cyc;
        bus.i_req = 1'b1; bus.i_addr = 6'd0;
        push(1'b0, 32'h00430822, 1'b0);
        tick();
        check("fetch_strobe", 32'({bus.mem_memread, bus.mem_memwrite}), 32'b10);
        check("fetch_addr", 32'(bus.mem_address), 32'd0);
        wait_ack(at);
        check("fetch_lat", 32'(at - s), 32'd2);
        tick();
        check("fetch_busy", 32'(bus.busy), 32'd0);

        // Store then load back.
        w0 = wr_cycles;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd8; bus.d_wdata = 32'hDEADBEEF;
        push(1'b1, 32'hCAFEF00D, 1'b0);
        tick();
        check("st_strobe", 32'({bus.mem_memread, bus.mem_memwrite}), 32'b01);
        check("st_wdata", bus.mem_writeData, 32'hDEADBEEF);
        check("st_addr", 32'(bus.mem_address), 32'd8);
        wait_ack(at);
        check("st_wr_cycles", 32'(wr_cycles - w0), 32'd1);
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        push(1'b1, 32'hDEADBEEF, 1'b0);
        wait_ack(at);
        tick();

        // Both requesting continuously: I,D,I,D at 3-cycle spacing.
        ov0 = overlap;
        bus.i_req = 1'b1; bus.i_addr = 6'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd8;
        push(1'b0, 32'h00430822, 1'b0);
        push(1'b1, 32'hDEADBEEF, 1'b0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            logic was_d;
            was_d = bus.d_ack;
            wait_ack(at);
            was_d = bus.d_ack;
            if (k > 0) check("rr_space", 32'(at - prev), 32'd3);
            prev = at;
            if (k < 2) begin
                if (was_d) begin
                    bus.d_req = 1'b1;
                    push(1'b1, 32'hDEADBEEF, 1'b0);
                end else begin
                    bus.i_req = 1'b1;
                    push(1'b0, 32'h00430822, 1'b0);
                end
            end
        end
        check("rr_overlap", 32'(overlap - ov0), 32'd0);
        tick();

        // Reset in the middle of a store's ACCESS cycle.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd24; bus.d_wdata = 32'h22222222;
        tick();
        check("abort_wr_on", 32'(bus.mem_memwrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wr_off", 32'({bus.mem_memwrite, bus.busy}), 32'd0);
        bus.d_req = 1'b0;
        tick();
        check("abort_noack1", 32'(bus.d_ack), 32'd0);
        tick();
        check("abort_noack2", 32'(bus.d_ack), 32'd0);
        rst_n = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd24;
        push(1'b1, 32'h11111111, 1'b0);
        wait_ack(at);
        tick();

`ifdef MEM_ARB_ALIGN_CHECK_EN
        bus.i_req = 1'b1; bus.i_addr = 6'd5;
        push(1'b0, 32'h00430822, 1'b1);
        tick();
        check("mis_strobe", 32'({bus.mem_memread, bus.mem_memwrite}), 32'd0);
        wait_ack(at);
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd48;
        push(1'b1, 32'h11111111, 1'b1);
        tick();
        check("top_strobe", 32'({bus.mem_memread, bus.mem_memwrite}), 32'd0);
        wait_ack(at);
        tick();
`endif
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd44;
        push(1'b1, 32'h44444444, 1'b0);
        wait_ack(at);
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
